// File: rtl/gates_pkg.sv
// Shared definitions for the equivalence monitor.
// Holds the FSM state encoding and the default sizing constants
// used by equiv_monitor and its saturating counters.
package gates_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Default sizing
   localparam int N_IN_DEF  = 2;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/equiv_monitor_sat_counter.sv
// sat_counter: CNT_W-wide up-counter that clears on clr and sticks at
// all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, forces count to 0
//   clr   - synchronous clear (wins over inc)
//   inc   - add one this edge unless already saturated
//   count - current value
module sat_counter #(
   parameter int CNT_W = gates_pkg::CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/equiv_monitor.sv
// equiv_monitor: compares a gate-level implementation against its
// expression-level reference over the full stimulus space (2**N_IN
// samples). Counts accepted samples and mismatches, then reports pass.
//
// Optional feature: define EQUIV_MONITOR_FIRSTFAIL_EN to add the
// first_fail_vec port, which records vec of the first mismatch of a run.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start             - pulse; begins a run from IDLE or DONE
//   in_valid/in_ready - sample handshake; ready only while running
//   vec               - stimulus vector of the current sample
//   ref_out, dut_out  - reference and gate-level responses
//   busy, done, pass  - run status; pass only meaningful with done
//   vec_count         - accepted samples this run (saturating)
//   err_count         - mismatching samples this run (saturating)
//   first_fail_vec    - (macro only) vec of first mismatch, else 0
module equiv_monitor
   import gates_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  vec,
   input  logic             ref_out,
   input  logic             dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] err_count
`ifdef EQUIV_MONITOR_FIRSTFAIL_EN
   ,
   output logic [N_IN-1:0]  first_fail_vec
`endif
);

   // vec_count value just before the final sample of a run is accepted
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'((1 << N_IN) - 1);

   logic [1:0] state;
   logic       accept;
   logic       mismatch;
   logic       new_run;

   assign accept   = in_valid && (state == ST_RUN);
   assign mismatch = ref_out != dut_out;
   // start is only honoured outside RUN
   assign new_run  = start && (state != ST_RUN);

   assign in_ready = (state == ST_RUN);
   assign busy     = (state == ST_RUN);
   assign done     = (state == ST_DONE);
   assign pass     = done && (err_count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) state <= ST_RUN;
            ST_RUN:  if (accept && (vec_count == LAST_IDX)) state <= ST_DONE;
            ST_DONE: if (start) state <= ST_RUN;
            default: state <= ST_IDLE;
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_vec_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (new_run),
      .inc   (accept),
      .count (vec_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (new_run),
      .inc   (accept && mismatch),
      .count (err_count)
   );

`ifdef EQUIV_MONITOR_FIRSTFAIL_EN
   // err_count is still zero exactly when this is the run's first mismatch
   always_ff @(posedge clk) begin
      if (rst || new_run) begin
         first_fail_vec <= '0;
      end else if (accept && mismatch && (err_count == '0)) begin
         first_fail_vec <= vec;
      end
   end
`else
   logic unused_vec;
   assign unused_vec = ^vec;
`endif

endmodule

// File: doc/equiv_monitor.md
EQUIV_MONITOR -- requirements
Module: equiv_monitor

Interface
REQ-001 Parameter N_IN, default 2: width of the stimulus vector under test.
REQ-002 Parameter CNT_W, default 8: width of the vector and error counters; SHALL satisfy CNT_W >= N_IN+1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a check run.
REQ-006 in_valid  input  1  stimulus/response sample is present on vec, ref_out and dut_out.
REQ-007 in_ready  output  1  monitor accepts a sample this cycle.
REQ-008 vec  input  N_IN  stimulus vector applied to both implementations.
REQ-009 ref_out  input  1  output of the expression-level (reference) implementation.
REQ-010 dut_out  input  1  output of the gate-level implementation.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  high in DONE.
REQ-013 pass  output  1  valid while done is high: 1 if err_count==0.
REQ-014 vec_count  output  CNT_W  number of samples accepted in the current run.
REQ-015 err_count  output  CNT_W  number of accepted samples with ref_out != dut_out.
REQ-016 first_fail_vec  output  N_IN  vec of the first mismatching sample (present only with the macro, REQ-031).

Function
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE->RUN on start; counters clear to 0 in the same edge.
REQ-019 in_ready SHALL be 1 only in RUN; a sample is accepted on an edge where in_valid && in_ready.
REQ-020 Each accepted sample increments vec_count by 1; if ref_out != dut_out it also increments err_count by 1, on the same edge.
REQ-021 Latency: counters reflect an accepted sample on the first edge after acceptance (registered, one-cycle).
REQ-022 RUN->DONE on the edge accepting the sample that makes vec_count equal 2**N_IN; in_ready drops the next cycle.
REQ-023 DONE->RUN on start (new run, counters cleared); otherwise DONE holds and outputs stay stable.
REQ-024 start during RUN SHALL be ignored.
REQ-025 start and in_valid in the same cycle in IDLE or DONE: start takes effect; the sample is not accepted.
REQ-026 Counters SHALL saturate at all-ones and never wrap.
REQ-027 in_valid outside RUN SHALL have no effect.
REQ-028 pass SHALL be 0 whenever done is 0.

Reset
REQ-029 rst SHALL force IDLE and set in_ready=0, busy=0, done=0, pass=0, vec_count=0, err_count=0, first_fail_vec=0; rst takes priority over start and in_valid.
REQ-030 rst asserted in mid-run SHALL abandon the run with no partial result retained.

Configuration
REQ-031 Macro EQUIV_MONITOR_FIRSTFAIL_EN defined: first_fail_vec port and register exist; captured on the first mismatch of a run and held until the next start or rst; 0 if no mismatch.
REQ-032 Macro undefined: the first_fail_vec port and register are absent; all other behaviour is identical.

Structure
REQ-033 Shared package gates_pkg SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default N_IN/CNT_W constants.
REQ-034 Sub-module sat_counter (CNT_W wide; inputs clr, inc; saturating) SHALL be instantiated twice, for vec_count and err_count.

Verification
REQ-035 N_IN=2; start, then 4 samples vec=00,01,10,11 with ref_out==dut_out -> done=1, pass=1, vec_count=4, err_count=0.
REQ-036 Same sequence with dut_out inverted at vec=10 and vec=11 -> err_count=2, pass=0, first_fail_vec=10 (macro on).
REQ-037 in_valid toggled 1,0,1,0 during RUN -> only cycles with in_valid high are counted; DONE reached after the 4th acceptance.
REQ-038 rst pulse after 2 accepted samples -> next cycle IDLE, all outputs 0; a fresh start counts from 0.
REQ-039 In DONE, pulse start with in_valid=1 -> RUN, counters 0, that sample is not counted.
REQ-040 CNT_W=2, N_IN=1, every sample mismatching -> err_count reaches 2 and DONE; force 5 mismatches with N_IN raised to 2 in a sat_counter unit test -> count holds at 3.
